// File: rtl/ex_muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_seq_pkg
//  Description : Shared types, encodings and helpers for the iterative RV32M
//                multiply/divide sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_muldiv_seq_pkg;

    // Default operand/result width of the sequencer.
    localparam int MD_XLEN = 32;

    // M-extension funct3 encodings.
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // All divide/remainder ops have funct3[2] set.
    function automatic logic op_is_div(input md_op_e op);
        return op[2];
    endfunction

    // REM and REMU return the remainder rather than the quotient.
    function automatic logic op_is_rem(input md_op_e op);
        return op[2] & op[1];
    endfunction

    // rs1 is treated as signed by MUL, MULH, MULHSU, DIV and REM.
    function automatic logic op_signed_a(input md_op_e op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is treated as signed by MUL, MULH, DIV and REM.
    function automatic logic op_signed_b(input md_op_e op);
        return (op == MD_MUL) || (op == MD_MULH) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage : ex_muldiv_seq_pkg
`default_nettype wire

// File: rtl/ex_muldiv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_seq_if
//  Description : EX-stage <-> multiply/divide sequencer handshake bundle.
//                The pipeline drives the op request and consumes the stall,
//                busy, done and result signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ex_muldiv_seq_if #(
    parameter int XLEN = ex_muldiv_seq_pkg::MD_XLEN
);
    logic            md_i_start;
    logic [2:0]      md_i_op;
    logic [XLEN-1:0] md_i_a;
    logic [XLEN-1:0] md_i_b;
    logic            md_i_flush;
    logic            md_o_stall;
    logic            md_o_busy;
    logic            md_o_done;
    logic [XLEN-1:0] md_o_result;

    // Pipeline (EX stage) side.
    modport master (
        output md_i_start, md_i_op, md_i_a, md_i_b, md_i_flush,
        input  md_o_stall, md_o_busy, md_o_done, md_o_result
    );

    // Sequencer side.
    modport slave (
        input  md_i_start, md_i_op, md_i_a, md_i_b, md_i_flush,
        output md_o_stall, md_o_busy, md_o_done, md_o_result
    );

endinterface : ex_muldiv_seq_if
`default_nettype wire

// File: rtl/ex_muldiv_fixup.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_fixup
//  Description : Combinational result stage. Applies the sign correction to
//                the magnitude product / quotient / remainder, substitutes the
//                divide-by-zero and signed-overflow results and selects the
//                requested half or operand.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_fixup
    import ex_muldiv_seq_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  var md_op_e          i_op,
    input  wire [2*XLEN-1:0]    i_acc,     // mul: magnitude product; div: {rem, quo}
    input  wire                 i_neg_a,   // rs1 negative and treated as signed
    input  wire                 i_neg_b,   // rs2 negative and treated as signed
    input  wire                 i_b_zero,  // rs2 == 0
    input  wire                 i_ovf,     // signed 0x80000000 / -1
    input  wire [XLEN-1:0]      i_a,       // raw rs1, returned as remainder on /0
    output logic [XLEN-1:0]     o_result
);

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;

    // Sign fix, special-case substitution and final result select.
    always_comb begin
        w_prod   = (i_neg_a ^ i_neg_b) ? -i_acc : i_acc;
        w_quo    = (i_neg_a ^ i_neg_b) ? -i_acc[XLEN-1:0] : i_acc[XLEN-1:0];
        w_rem    = i_neg_a ? -i_acc[2*XLEN-1:XLEN] : i_acc[2*XLEN-1:XLEN];
        o_result = '0;
        if (op_is_div(i_op)) begin
            if (i_b_zero) begin
                w_quo = '1;
                w_rem = i_a;
            end else if (i_ovf) begin
                w_quo = {1'b1, {(XLEN-1){1'b0}}};
                w_rem = '0;
            end
            o_result = op_is_rem(i_op) ? w_rem : w_quo;
        end else if (!i_b_zero) begin
            // A zero multiplier short-circuits with a zero product.
            o_result = (i_op == MD_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        end
    end

endmodule : ex_muldiv_fixup
`default_nettype wire

// File: rtl/ex_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_seq
//  Description : Iterative RV32M multiply/divide sequencer beside the EX-stage
//                ALU. One bit per cycle shift-add multiply or restoring divide
//                on operand magnitudes, followed by a sign fix. Stalls the
//                pipeline while running; flush aborts the op.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_seq
    import ex_muldiv_seq_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  wire              clk,
    input  wire              rst,
    ex_muldiv_seq_if.slave   md
);

    localparam int                 CNT_W      = $clog2(XLEN);
    localparam logic [CNT_W-1:0]   c_cnt_init = CNT_W'(XLEN - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    md_state_e          r_state;
    md_op_e             r_op;
    logic [XLEN-1:0]    r_opnd;     // mul: |a| multiplicand; div: |b| divisor
    logic [2*XLEN-1:0]  r_acc;      // mul: {partial, multiplier}; div: {rem, quo}
    logic               r_neg_a;
    logic               r_neg_b;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic               r_busy;
    logic [XLEN-1:0]    r_result;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    md_op_e             w_op;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [XLEN-1:0]    w_a_mag;
    logic [XLEN-1:0]    w_b_mag;
    logic               w_b_zero;
    logic               w_ovf;
    logic               w_accept;

    // Operand magnitudes and special-case detection for the incoming op.
    always_comb begin
        w_op     = md_op_e'(md.md_i_op);
        w_neg_a  = op_signed_a(w_op) & md.md_i_a[XLEN-1];
        w_neg_b  = op_signed_b(w_op) & md.md_i_b[XLEN-1];
        w_a_mag  = w_neg_a ? -md.md_i_a : md.md_i_a;
        w_b_mag  = w_neg_b ? -md.md_i_b : md.md_i_b;
        w_b_zero = (md.md_i_b == '0);
        w_ovf    = ((w_op == MD_DIV) || (w_op == MD_REM)) &&
                   (md.md_i_a == {1'b1, {(XLEN-1){1'b0}}}) && (&md.md_i_b);
        w_accept = (r_state == ST_IDLE) && md.md_i_start && !md.md_i_flush;
    end

    // ------------------------------------------------------------------
    // One iteration of the datapath
    // ------------------------------------------------------------------
    logic [XLEN:0]      w_mul_sum;
    logic [XLEN:0]      w_div_shift;
    logic [XLEN:0]      w_div_diff;
    logic [2*XLEN-1:0]  w_acc_next;

    // Shift-add multiply step or restoring divide step on the accumulator.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                      (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
        w_div_shift = r_acc[2*XLEN-1:XLEN-1];
        w_div_diff  = w_div_shift - {1'b0, r_opnd};
        if (op_is_div(r_op)) begin
            // A borrow out of the XLEN+1-bit subtract means the divisor did not fit.
            if (w_div_diff[XLEN])
                w_acc_next = {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            else
                w_acc_next = {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end else begin
            w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Result fix-up: fed from the request in IDLE (special cases finish
    // there) and from the last iteration while in CALC.
    // ------------------------------------------------------------------
    md_op_e             w_fix_op;
    logic [2*XLEN-1:0]  w_fix_acc;
    logic               w_fix_neg_a;
    logic               w_fix_neg_b;
    logic               w_fix_b_zero;
    logic               w_fix_ovf;
    logic [XLEN-1:0]    w_fix_result;

    // Select fix-up inputs according to where the op finishes.
    always_comb begin
        w_fix_op     = r_op;
        w_fix_acc    = w_acc_next;
        w_fix_neg_a  = r_neg_a;
        w_fix_neg_b  = r_neg_b;
        w_fix_b_zero = 1'b0;
        w_fix_ovf    = 1'b0;
        if (r_state == ST_IDLE) begin
            w_fix_op     = w_op;
            w_fix_acc    = '0;
            w_fix_neg_a  = w_neg_a;
            w_fix_neg_b  = w_neg_b;
            w_fix_b_zero = w_b_zero;
            w_fix_ovf    = w_ovf;
        end
    end

    ex_muldiv_fixup #(
        .XLEN (XLEN)
    ) u_fixup (
        .i_op     (w_fix_op),
        .i_acc    (w_fix_acc),
        .i_neg_a  (w_fix_neg_a),
        .i_neg_b  (w_fix_neg_b),
        .i_b_zero (w_fix_b_zero),
        .i_ovf    (w_fix_ovf),
        .i_a      (md.md_i_a),
        .o_result (w_fix_result)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM with registered done/busy/result.
    // ------------------------------------------------------------------
    // Accept, iterate, publish the result for one cycle; flush aborts anywhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op     <= MD_MUL;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_op;
                        r_neg_a <= w_neg_a;
                        r_neg_b <= w_neg_b;
                        r_cnt   <= c_cnt_init;
                        r_busy  <= 1'b1;
                        if (op_is_div(w_op)) begin
                            r_opnd <= w_b_mag;
                            r_acc  <= {{XLEN{1'b0}}, w_a_mag};
                        end else begin
                            r_opnd <= w_a_mag;
                            r_acc  <= {{XLEN{1'b0}}, w_b_mag};
                        end
                        if (w_b_zero || w_ovf) begin
                            r_state  <= ST_DONE;
                            r_done   <= 1'b1;
                            r_result <= w_fix_result;
                        end else begin
                            r_state  <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (md.md_i_flush) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= w_acc_next;
                        if (r_cnt == '0) begin
                            r_state  <= ST_DONE;
                            r_done   <= 1'b1;
                            r_result <= w_fix_result;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // Start is not looked at here; EX re-presents it next cycle.
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stall covers the accept cycle and every iteration; it drops in DONE.
    assign md.md_o_stall  = !rst && (w_accept || (r_state == ST_CALC));
    assign md.md_o_busy   = r_busy;
    assign md.md_o_done   = r_done;
    assign md.md_o_result = r_result;

endmodule : ex_muldiv_seq
`default_nettype wire

// File: tb/tb_ex_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv_seq
//  Description : Self-checking bench for ex_muldiv_seq. Directed RV32M cases,
//                randomized ops against an arithmetic reference model, flush,
//                start-in-DONE, back-to-back and asynchronous reset scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_seq;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [31:0] last_res;

    ex_muldiv_seq_if md_if ();

    ex_muldiv_seq dut (
        .clk (clk),
        .rst (rst),
        .md  (md_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result straight from the RV32M arithmetic definitions.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb, ub;
        int          ia, ib;
        ia = a; ib = b;
        sa = ia; sb = ib;
        ub = {32'b0, b};
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles from the accepting edge to the first cycle showing done.
    function automatic int model_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op from an IDLE cycle (#1 after an edge), follow it to done
    // and back to IDLE.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_res;
        int          exp_lat;
        int          k;
        bit          seen;
        int          bad;
        exp_res = model(op, a, b);
        exp_lat = model_latency(op, a, b);
        md_if.md_i_start = 1'b1;
        md_if.md_i_op    = op;
        md_if.md_i_a     = a;
        md_if.md_i_b     = b;
        #1;
        n_checks++;
        if (md_if.md_o_stall !== 1'b1) begin
            n_fail++; $display("FAIL accept_stall op=%0d: got %b want 1", op, md_if.md_o_stall);
        end
        @(posedge clk); #1;
        md_if.md_i_start = 1'b0;
        md_if.md_i_a     = $urandom;
        md_if.md_i_b     = $urandom;
        k = 1; seen = 1'b0; bad = 0;
        while (!seen && k <= 40) begin
            if (md_if.md_o_done === 1'b1) seen = 1'b1;
            else begin
                if (md_if.md_o_stall !== 1'b1 || md_if.md_o_busy !== 1'b1) bad++;
                @(posedge clk); #1;
                k++;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL done_timeout op=%0d a=%h b=%h: no done in 40 cycles", op, a, b);
        end
        n_checks++;
        if (k != exp_lat) begin
            n_fail++; $display("FAIL latency op=%0d a=%h b=%h: got %0d want %0d", op, a, b, k, exp_lat);
        end
        n_checks++;
        if (md_if.md_o_result !== exp_res) begin
            n_fail++; $display("FAIL result op=%0d a=%h b=%h: got %h want %h", op, a, b, md_if.md_o_result, exp_res);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL calc_stall_busy op=%0d: %0d cycles with stall/busy low, want 0", op, bad);
        end
        n_checks++;
        if (md_if.md_o_stall !== 1'b0 || md_if.md_o_busy !== 1'b1) begin
            n_fail++; $display("FAIL done_cycle op=%0d: stall=%b busy=%b want stall=0 busy=1", op, md_if.md_o_stall, md_if.md_o_busy);
        end
        last_res = exp_res;
        @(posedge clk); #1;
        n_checks++;
        if (md_if.md_o_done !== 1'b0 || md_if.md_o_busy !== 1'b0) begin
            n_fail++; $display("FAIL back_to_idle op=%0d: done=%b busy=%b want 0 0", op, md_if.md_o_done, md_if.md_o_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        md_if.md_i_start = 1'b1;
        md_if.md_i_op    = 3'd0;
        md_if.md_i_a     = 32'd3;
        md_if.md_i_b     = 32'd4;
        md_if.md_i_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (md_if.md_o_busy !== 1'b0 || md_if.md_o_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: busy=%b done=%b want 0 0", md_if.md_o_busy, md_if.md_o_done);
        end
        n_checks++;
        if (md_if.md_o_result !== 32'h0) begin
            n_fail++; $display("FAIL reset_result: got %h want 00000000", md_if.md_o_result);
        end
        n_checks++;
        if (md_if.md_o_stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b want 0 with start high", md_if.md_o_stall);
        end
        md_if.md_i_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        last_res = 32'h0;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
        logic [31:0] as  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                  32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'd2, 32'd2, 32'd7, 32'd7,
                                  32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 12; i++) do_op(ops[i], as[i], bs[i]);
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            do_op(op, a, b);
        end
    endtask

    task automatic test_flush();
        // Flush together with start in IDLE: start is not taken.
        md_if.md_i_start = 1'b1;
        md_if.md_i_flush = 1'b1;
        md_if.md_i_op    = 3'd5;
        md_if.md_i_a     = 32'd50;
        md_if.md_i_b     = 32'd3;
        #1;
        n_checks++;
        if (md_if.md_o_stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_start_stall: got %b want 0", md_if.md_o_stall);
        end
        @(posedge clk); #1;
        md_if.md_i_flush = 1'b0;
        n_checks++;
        if (md_if.md_o_busy !== 1'b0 || md_if.md_o_done !== 1'b0) begin
            n_fail++; $display("FAIL flush_start_ignored: busy=%b done=%b want 0 0", md_if.md_o_busy, md_if.md_o_done);
        end
        // Start is now accepted; abort it in its 10th CALC cycle.
        @(posedge clk); #1;
        md_if.md_i_start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        n_checks++;
        if (md_if.md_o_busy !== 1'b1) begin
            n_fail++; $display("FAIL flush_pre_busy: got %b want 1", md_if.md_o_busy);
        end
        md_if.md_i_flush = 1'b1;
        @(posedge clk); #1;
        md_if.md_i_flush = 1'b0;
        n_checks++;
        if (md_if.md_o_busy !== 1'b0 || md_if.md_o_done !== 1'b0 || md_if.md_o_stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_abort: busy=%b done=%b stall=%b want 0 0 0",
                               md_if.md_o_busy, md_if.md_o_done, md_if.md_o_stall);
        end
        n_checks++;
        if (md_if.md_o_result !== last_res) begin
            n_fail++; $display("FAIL flush_result_kept: got %h want %h", md_if.md_o_result, last_res);
        end
        do_op(3'd5, 32'd9, 32'd3);
    endtask

    task automatic test_start_in_done();
        int  k;
        bit  seen;
        md_if.md_i_start = 1'b1;
        md_if.md_i_op    = 3'd5;
        md_if.md_i_a     = 32'd5;
        md_if.md_i_b     = 32'd0;
        @(posedge clk); #1;
        n_checks++;
        if (md_if.md_o_done !== 1'b1 || md_if.md_o_result !== model(3'd5, 32'd5, 32'd0)) begin
            n_fail++; $display("FAIL divz_done: done=%b result=%h want 1 %h",
                               md_if.md_o_done, md_if.md_o_result, model(3'd5, 32'd5, 32'd0));
        end
        md_if.md_i_op = 3'd0;
        md_if.md_i_a  = 32'd6;
        md_if.md_i_b  = 32'd7;
        #1;
        n_checks++;
        if (md_if.md_o_stall !== 1'b0) begin
            n_fail++; $display("FAIL done_ignores_start_stall: got %b want 0", md_if.md_o_stall);
        end
        @(posedge clk); #1;
        n_checks++;
        if (md_if.md_o_busy !== 1'b0 || md_if.md_o_done !== 1'b0 || md_if.md_o_stall !== 1'b1) begin
            n_fail++; $display("FAIL done_ignores_start: busy=%b done=%b stall=%b want 0 0 1",
                               md_if.md_o_busy, md_if.md_o_done, md_if.md_o_stall);
        end
        @(posedge clk); #1;
        md_if.md_i_start = 1'b0;
        k = 1; seen = 1'b0;
        while (!seen && k <= 40) begin
            if (md_if.md_o_done === 1'b1) seen = 1'b1;
            else begin @(posedge clk); #1; k++; end
        end
        n_checks++;
        if (!seen || k != 33 || md_if.md_o_result !== model(3'd0, 32'd6, 32'd7)) begin
            n_fail++; $display("FAIL reaccept_mul: seen=%b lat=%0d result=%h want 1 33 %h",
                               seen, k, md_if.md_o_result, model(3'd0, 32'd6, 32'd7));
        end
        last_res = model(3'd0, 32'd6, 32'd7);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            do_op(3'(i + 2), $urandom, (i == 3) ? 32'd0 : $urandom);
    endtask

    task automatic test_async_reset();
        md_if.md_i_start = 1'b1;
        md_if.md_i_op    = 3'd1;
        md_if.md_i_a     = $urandom;
        md_if.md_i_b     = $urandom | 32'h1;
        @(posedge clk); #1;
        md_if.md_i_start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (md_if.md_o_busy !== 1'b0 || md_if.md_o_done !== 1'b0) begin
            n_fail++; $display("FAIL async_rst_flags: busy=%b done=%b want 0 0", md_if.md_o_busy, md_if.md_o_done);
        end
        n_checks++;
        if (md_if.md_o_result !== 32'h0 || md_if.md_o_stall !== 1'b0) begin
            n_fail++; $display("FAIL async_rst_out: result=%h stall=%b want 00000000 0", md_if.md_o_result, md_if.md_o_stall);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        last_res = 32'h0;
        do_op(3'd7, 32'd100, 32'd7);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_res = 32'h0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_start_in_done();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_ex_muldiv_seq
`default_nettype wire
